// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester, response and memory-port signals of the memory arbiter.
// Latency: none, wiring only.
// Backpressure: slave = arbiter side, master = requesters plus memory model side.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef BLOCK_SIZE
`define BLOCK_SIZE 128
`endif

interface mem_arbiter_if #(
  parameter int ADDR_W = `WORD_SIZE,
  parameter int DATA_W = `BLOCK_SIZE
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              i_done;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_done;
  logic              err;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    output i_rdata, i_done, d_rdata, d_done, err, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    input  i_rdata, i_done, d_rdata, d_done, err, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one block-wide memory port between icache refill and dcache refill/write-back.
// Latency: grant at the edge after req, done pulse at least 2 cycles after req; outputs decode registers only.
// Backpressure: losers wait in IDLE holding req; memory stalls via mem_ready, aborted after TIMEOUT cycles.
// Tie-break: ARB_ROUND_ROBIN_EN defined -> round robin, undefined -> dcache has fixed priority.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef BLOCK_SIZE
`define BLOCK_SIZE 128
`endif

module mem_arbiter #(
  parameter int ADDR_W  = `WORD_SIZE,
  parameter int DATA_W  = `BLOCK_SIZE,
  parameter int TIMEOUT = 255
) (
  input logic          clk,
  input logic          rst_n,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY, RESP} state_t;

  // Counter value at which one more stalled cycle means the memory took TIMEOUT cycles.
  localparam logic [7:0] LP_TO_LAST = 8'(TIMEOUT - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [7:0]        r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic              r_we;
  logic [DATA_W-1:0] r_wdata;
  logic              r_own_d;
  logic              r_err_pend;
  logic [DATA_W-1:0] r_i_rdata;
  logic [DATA_W-1:0] r_d_rdata;
  logic              w_busy;
  logic              w_pick_d;
  logic              w_grant_i;
  logic              w_grant_d;
  logic              w_to_hit;

  assign w_busy   = (r_state == I_BUSY) || (r_state == D_BUSY);
  assign w_to_hit = (r_cnt == LP_TO_LAST);

`ifdef ARB_ROUND_ROBIN_EN
  logic r_last_d;

  // On a tie serve whoever was not served last; the icache wins the first tie after reset.
  assign w_pick_d = bus.d_req & (~bus.i_req | ~r_last_d);

  // Remember which requester got the most recent grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_d <= 1'b1;
    end else if (w_grant_i || w_grant_d) begin
      r_last_d <= w_grant_d;
    end
  end
`else
  // Fixed priority: the dcache always wins a tie.
  assign w_pick_d = bus.d_req;
`endif

  // State register; reset aborts any transaction without a done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, grant and handshake outputs, all decoded from registered state.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_i   = 1'b0;
    w_grant_d   = 1'b0;
    bus.mem_en  = 1'b0;
    bus.mem_we  = 1'b0;
    bus.i_done  = 1'b0;
    bus.d_done  = 1'b0;
    bus.err     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pick_d) begin
          w_grant_d   = 1'b1;
          w_state_nxt = D_BUSY;
        end else if (bus.i_req) begin
          w_grant_i   = 1'b1;
          w_state_nxt = I_BUSY;
        end
      end
      I_BUSY, D_BUSY: begin
        bus.mem_en = 1'b1;
        bus.mem_we = (r_state == D_BUSY) && r_we;
        if (bus.mem_ready || w_to_hit) begin
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        bus.i_done  = ~r_own_d;
        bus.d_done  = r_own_d;
        bus.err     = r_err_pend;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Capture the winning request at grant, then count stalls and collect read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_addr     <= '0;
      r_we       <= 1'b0;
      r_wdata    <= '0;
      r_own_d    <= 1'b0;
      r_err_pend <= 1'b0;
      r_i_rdata  <= '0;
      r_d_rdata  <= '0;
    end else if (w_grant_i || w_grant_d) begin
      r_cnt      <= '0;
      r_err_pend <= 1'b0;
      r_own_d    <= w_grant_d;
      r_addr     <= w_grant_d ? bus.d_addr : bus.i_addr;
      r_we       <= w_grant_d & bus.d_we;
      if (w_grant_d) begin
        r_wdata <= bus.d_wdata;
      end
    end else if (w_busy) begin
      if (bus.mem_ready) begin
        // Ready on the last allowed cycle still counts as success.
        if (!r_own_d) begin
          r_i_rdata <= bus.mem_rdata;
        end else if (!r_we) begin
          r_d_rdata <= bus.mem_rdata;
        end
      end else begin
        r_cnt <= r_cnt + 8'd1;
        if (w_to_hit) begin
          r_err_pend <= 1'b1;
        end
      end
    end
  end

  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign bus.i_rdata   = r_i_rdata;
  assign bus.d_rdata   = r_d_rdata;

endmodule
